ram_sum_reader: RTL and testbench

RAM_SUM_READER -- requirements
Module: ram_sum_reader

---
 rtl/ram_sum_reader_pkg.sv | 18 +
 rtl/ram_sum_reader_sum_check.sv | 28 ++
 rtl/ram_sum_reader.sv | 120 ++++++++++++
 tb/tb_ram_sum_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sum_reader_pkg.sv
// Shared definitions for the RAM sum reader: default widths and FSM state encoding.
package ram_sum_reader_pkg;

    // Default RAM geometry: two 4-bit operands packed into an 8-bit address,
    // and a 5-bit data word that holds their full (untruncated) sum.
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = DEF_ADDR_W / 2 + 1;

    // Sweep controller states; the encoding is fixed so it can be probed externally.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        PRES = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_sum_reader_sum_check.sv
// Expected-value generator and comparator: the RAM entry at {A,B} should hold A+B.
module sum_check
    import ram_sum_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA,
    output logic [DATA_W-1:0] EXP,
    output logic              ERR
);

    localparam int HALF_W = ADDR_W / 2;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Split the address into its two operands and widen both before adding,
    // so the carry out of the half-width add is kept.
    always_comb begin
        op_a = DATA_W'(ADDR[ADDR_W-1:HALF_W]);
        op_b = DATA_W'(ADDR[HALF_W-1:0]);
        EXP  = op_a + op_b;
        ERR  = (DATA != EXP);
    end

endmodule

// File: rtl/ram_sum_reader.sv
// Read-only RAM sweeper: walks every address once, presents each entry on a
// valid/ready stream together with a flag telling whether it differs from
// the sum of the two address halves, and counts the mismatches.
module ram_sum_reader
    import ram_sum_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              RAM_CS,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    input  logic [DATA_W-1:0] RAM_DOUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] OUT_ADDR,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_ERR,
    output logic [ADDR_W:0]   ERR_CNT
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [DATA_W-1:0] exp_sum;
    logic              cap_err;

    // The expected sum is only kept for debug visibility; the flag is what matters.
    logic              unused_exp;
    assign unused_exp = ^exp_sum;

    // This master never writes.
    assign RAM_WE = 1'b0;

    sum_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sum_check (
        .ADDR (addr_cnt),
        .DATA (RAM_DOUT),
        .EXP  (exp_sum),
        .ERR  (cap_err)
    );

    // Sweep FSM: every output is registered and set on the transition into the
    // state where it must be visible, so RAM_CS is high exactly for the RD cycle
    // and DONE exactly for the FIN cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            ERR_CNT   <= '0;
            OUT_ADDR  <= '0;
            OUT_DATA  <= '0;
            OUT_ERR   <= 1'b0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            RAM_CS    <= 1'b0;
            RAM_ADDR  <= '0;
        end else begin
            DONE   <= 1'b0;
            RAM_CS <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        addr_cnt <= '0;
                        ERR_CNT  <= '0;
                        RAM_ADDR <= '0;
                        RAM_CS   <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: begin
                    // RAM samples CS/ADDR on this edge; data arrives during CAP.
                    state <= CAP;
                end
                CAP: begin
                    OUT_ADDR  <= addr_cnt;
                    OUT_DATA  <= RAM_DOUT;
                    OUT_ERR   <= cap_err;
                    OUT_VALID <= 1'b1;
                    state     <= PRES;
                end
                PRES: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        ERR_CNT   <= ERR_CNT + (ADDR_W + 1)'(OUT_ERR);
                        if (addr_cnt == LAST_ADDR) begin
                            DONE  <= 1'b1;
                            state <= FIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                            RAM_ADDR <= addr_cnt + 1'b1;
                            RAM_CS   <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY      <= 1'b0;
                    OUT_VALID <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sum_reader.sv
// Scoreboard bench for ram_sum_reader: a behavioural registered-read RAM,
// directed sweeps (clean, start-while-busy, corrupted+stall, mid-sweep reset,
// all-zero) and a decoupled monitor that checks every handshaked beat.
module tb_ram_sum_reader;

    localparam int AW = 8;
    localparam int DW = 5;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic          RAM_CS;
    logic          RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DOUT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [AW-1:0] OUT_ADDR;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_ERR;
    logic [AW:0]   ERR_CNT;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } beat_t;

    beat_t         sb[$];
    logic [DW-1:0] mem [256];
    int            vectors = 0;
    int            miscompares = 0;

    ram_sum_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RAM_CS    (RAM_CS),
        .RAM_WE    (RAM_WE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_DOUT  (RAM_DOUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ADDR  (OUT_ADDR),
        .OUT_DATA  (OUT_DATA),
        .OUT_ERR   (OUT_ERR),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural RAM with one-cycle registered read.
    initial RAM_DOUT = '0;
    always @(posedge CLK) begin
        if (RAM_CS && !RAM_WE) RAM_DOUT <= mem[RAM_ADDR];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {24'd0, OUT_ADDR}, 32'hFFFF_FFFF);
            end else begin
                beat_t b;
                b = sb.pop_front();
                chk("beat_addr", {24'd0, OUT_ADDR}, {24'd0, b.addr});
                chk("beat_data", {27'd0, OUT_DATA}, {27'd0, b.data});
                chk("beat_err",  {31'd0, OUT_ERR},  {31'd0, b.err});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] sum_of(input int a);
        return DW'(a / 16) + DW'(a % 16);
    endfunction

    task automatic fill_good();
        for (int i = 0; i < 256; i++) mem[i] = sum_of(i);
    endtask

    task automatic push_range(input int last);
        for (int i = 0; i <= last; i++) begin
            beat_t b;
            b.addr = AW'(i);
            b.data = mem[i];
            b.err  = (mem[i] != sum_of(i));
            sb.push_back(b);
        end
    endtask

    // One sweep; cycle 1 is the RD cycle following the START-sampling edge.
    task automatic run_sweep(input string tag, input int exp_done, input int exp_errs,
                             input bit stall, input bit extra_start);
        int cyc;
        bit done;
        push_range(255);
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
            START = (extra_start && (cyc == 100 || cyc == 101)) ? 1'b1 : 1'b0;
            if (stall && RAM_CS && RAM_ADDR == 8'h10) begin
                int w;
                OUT_READY = 1'b0;
                w = 0;
                while (!OUT_VALID && w < 5) begin
                    tick();
                    cyc++;
                    w++;
                end
                for (int i = 0; i < 10; i++) begin
                    chk("stall_valid", {31'd0, OUT_VALID}, 32'd1);
                    chk("stall_addr",  {24'd0, OUT_ADDR},  32'h10);
                    chk("stall_data",  {27'd0, OUT_DATA},  32'd1);
                    chk("stall_no_cs", {31'd0, RAM_CS},    32'd0);
                    tick();
                    cyc++;
                end
                OUT_READY = 1'b1;
            end
            if (DONE) done = 1'b1;
        end
        START = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_done_cycle"}, cyc, exp_done);
        chk({tag, "_err_cnt"}, {23'd0, ERR_CNT}, exp_errs);
        chk({tag, "_busy_in_fin"}, {31'd0, BUSY}, 32'd1);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, DONE}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, BUSY}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_no_second_done"}, {31'd0, DONE}, 32'd0);
        end
        chk({tag, "_err_cnt_hold"}, {23'd0, ERR_CNT}, exp_errs);
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      {31'd0, BUSY},      32'd0);
        chk({tag, "_done"},      {31'd0, DONE},      32'd0);
        chk({tag, "_ram_cs"},    {31'd0, RAM_CS},    32'd0);
        chk({tag, "_ram_we"},    {31'd0, RAM_WE},    32'd0);
        chk({tag, "_ram_addr"},  {24'd0, RAM_ADDR},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_out_addr"},  {24'd0, OUT_ADDR},  32'd0);
        chk({tag, "_out_data"},  {27'd0, OUT_DATA},  32'd0);
        chk({tag, "_out_err"},   {31'd0, OUT_ERR},   32'd0);
        chk({tag, "_err_cnt"},   {23'd0, ERR_CNT},   32'd0);
    endtask

    // Sweep interrupted by reset while entry 0x80 is being read.
    task automatic run_reset_sweep();
        int cyc;
        bit hit;
        push_range(8'h7F);
        START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 1;
        hit = 1'b0;
        while (!hit && cyc < 3000) begin
            tick();
            cyc++;
            if (RAM_CS && RAM_ADDR == 8'h80) hit = 1'b1;
        end
        chk("rst_reached_80", {31'd0, hit}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        tick();
        chk_all_zero("rst_held");
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_access", {31'd0, RAM_CS}, 32'd0);
            chk("rst_idle", {31'd0, BUSY}, 32'd0);
        end
        chk("rst_sb_consumed", sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        RST_N     = 1'b1;
        START     = 1'b0;
        OUT_READY = 1'b1;
        fill_good();
        #2;
        RST_N = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Clean RAM, full-speed sweep.
        run_sweep("clean", 769, 0, 1'b0, 1'b0);

        // START re-asserted mid-sweep must be ignored.
        run_sweep("restart_ignored", 769, 0, 1'b0, 1'b1);

        // Two corrupted entries plus a 10-cycle consumer stall at 0x10.
        mem[8'h23] = 5'd9;
        mem[8'hFF] = 5'd0;
        run_sweep("corrupt_stall", 779, 2, 1'b1, 1'b0);

        // Reset mid-sweep, then a full sweep must restart at 0x00.
        fill_good();
        run_reset_sweep();
        run_sweep("after_reset", 769, 0, 1'b0, 1'b0);

        // All-zero RAM: only address 0x00 matches.
        for (int i = 0; i < 256; i++) mem[i] = '0;
        run_sweep("zeros", 769, 255, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
